// File: rtl/iic_seq.sv
// Register-level transaction sequencer for iic_core: expands one write or read
// request into the start/stop/byte pulse sequence and reports completion.
module iic_seq #(
   parameter int ACCEPT_WAIT = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic       rsp_err,
   output logic [7:0] rsp_rdata,
   output logic       core_start,
   output logic       core_stop,
   output logic       core_rw,
   output logic [7:0] core_din,
   input  logic [7:0] core_dout,
   input  logic       core_busy
);

   localparam int LIMIT = (TIMEOUT > ACCEPT_WAIT) ? TIMEOUT : ACCEPT_WAIT;
   localparam int CW    = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] ACC_LAST = CW'(ACCEPT_WAIT - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      LAUNCH    = 4'd1,
      WAIT_ACC  = 4'd2,
      WAIT_DONE = 4'd3,
      STOP      = 4'd4,
      STOP_ACC  = 4'd5,
      STOP_DONE = 4'd6,
      ABORT     = 4'd7,
      ABORT_END = 4'd8,
      RESP      = 4'd9
   } state_t;

   state_t        state_r;
   logic [2:0]    step_r;
   logic [CW-1:0] cnt_r;
   logic          rw_r;
   logic [6:0]    dev_r;
   logic [7:0]    reg_r;
   logic [7:0]    wdata_r;
   logic          err_r;
   logic          req_ready_r;
   logic          rsp_valid_r;
   logic          rsp_err_r;
   logic [7:0]    rsp_rdata_r;
   logic          core_start_r;
   logic          core_stop_r;
   logic          core_rw_r;
   logic [7:0]    core_din_r;

   // Steps: write = A, reg, data, STOP; read = A, reg, STOP, A|1, rd-byte, STOP.
   function automatic logic step_is_stop(input logic rw, input logic [2:0] step);
      if (rw) begin
         step_is_stop = (step == 3'd2) || (step == 3'd5);
      end else begin
         step_is_stop = (step == 3'd3);
      end
   endfunction

   function automatic logic step_is_final(input logic rw, input logic [2:0] step);
      if (rw) begin
         step_is_final = (step == 3'd5);
      end else begin
         step_is_final = (step == 3'd3);
      end
   endfunction

   // Returns {core_rw, core_din} for a byte step; step 2 only launches for writes.
   function automatic logic [8:0] step_byte(input logic [2:0] step, input logic [6:0] dev,
                                            input logic [7:0] rg, input logic [7:0] wd);
      case (step)
         3'd0:    step_byte = {1'b0, dev, 1'b0};
         3'd1:    step_byte = {1'b0, rg};
         3'd2:    step_byte = {1'b0, wd};
         3'd3:    step_byte = {1'b0, dev, 1'b1};
         3'd4:    step_byte = {1'b1, 8'h00};
         default: step_byte = 9'h000;
      endcase
   endfunction

   // Sequencer state machine with all outputs registered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         step_r       <= 3'd0;
         cnt_r        <= CNT_ZERO;
         rw_r         <= 1'b0;
         dev_r        <= 7'h00;
         reg_r        <= 8'h00;
         wdata_r      <= 8'h00;
         err_r        <= 1'b0;
         req_ready_r  <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_err_r    <= 1'b0;
         rsp_rdata_r  <= 8'h00;
         core_start_r <= 1'b0;
         core_stop_r  <= 1'b0;
         core_rw_r    <= 1'b0;
         core_din_r   <= 8'h00;
      end else begin
         core_start_r <= 1'b0;
         core_stop_r  <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_err_r    <= 1'b0;
         case (state_r)
            IDLE: begin
               req_ready_r <= 1'b1;
               if (req_valid && req_ready_r) begin
                  req_ready_r <= 1'b0;
                  rw_r        <= req_rw;
                  dev_r       <= req_dev;
                  reg_r       <= req_reg;
                  wdata_r     <= req_wdata;
                  step_r      <= 3'd0;
                  state_r     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (!core_busy) begin
                  core_start_r            <= 1'b1;
                  {core_rw_r, core_din_r} <= step_byte(step_r, dev_r, reg_r, wdata_r);
                  cnt_r                   <= CNT_ZERO;
                  state_r                 <= WAIT_ACC;
               end
            end
            WAIT_ACC, STOP_ACC: begin
               if (core_busy) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= (state_r == WAIT_ACC) ? WAIT_DONE : STOP_DONE;
               end else if (cnt_r == ACC_LAST) begin
                  err_r   <= 1'b1;
                  cnt_r   <= CNT_ZERO;
                  state_r <= ABORT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            WAIT_DONE: begin
               if (!core_busy) begin
                  if (core_rw_r) begin
                     rsp_rdata_r <= core_dout;
                  end
                  step_r  <= step_r + 3'd1;
                  state_r <= step_is_stop(rw_r, step_r + 3'd1) ? STOP : LAUNCH;
               end else if (cnt_r == TO_LAST) begin
                  err_r   <= 1'b1;
                  cnt_r   <= CNT_ZERO;
                  state_r <= ABORT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STOP: begin
               if (!core_busy) begin
                  core_stop_r <= 1'b1;
                  cnt_r       <= CNT_ZERO;
                  state_r     <= STOP_ACC;
               end
            end
            STOP_DONE: begin
               if (!core_busy) begin
                  if (step_is_final(rw_r, step_r)) begin
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= err_r;
                     state_r     <= RESP;
                  end else begin
                     step_r  <= step_r + 3'd1;
                     state_r <= LAUNCH;
                  end
               end else if (cnt_r == TO_LAST) begin
                  err_r   <= 1'b1;
                  cnt_r   <= CNT_ZERO;
                  state_r <= ABORT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            // Abort: one unchecked stop once the core idles, or give up silently.
            ABORT: begin
               if (!core_busy) begin
                  core_stop_r <= 1'b1;
                  state_r     <= ABORT_END;
               end else if (cnt_r == TO_LAST) begin
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= err_r;
                  state_r     <= RESP;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ABORT_END: begin
               rsp_valid_r <= 1'b1;
               rsp_err_r   <= err_r;
               state_r     <= RESP;
            end
            RESP: begin
               err_r       <= 1'b0;
               req_ready_r <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_err    = rsp_err_r;
   assign rsp_rdata  = rsp_rdata_r;
   assign core_start = core_start_r;
   assign core_stop  = core_stop_r;
   assign core_rw    = core_rw_r;
   assign core_din   = core_din_r;

endmodule

// File: tb/tb_iic_seq.sv
// Randomized bench for iic_seq: a behavioural iic_core model plus a step-list
// reference of the expected pulse sequence per request.
module tb_iic_seq;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [6:0] req_dev = 7'h00;
   logic [7:0] req_reg = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_err;
   logic [7:0] rsp_rdata;
   logic       core_start;
   logic       core_stop;
   logic       core_rw;
   logic [7:0] core_din;
   logic [7:0] core_dout = 8'h00;
   logic       core_busy;

   always #5 clock = ~clock;

   iic_seq #(.ACCEPT_WAIT(8), .TIMEOUT(1024)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .core_start(core_start), .core_stop(core_stop), .core_rw(core_rw),
      .core_din(core_din), .core_dout(core_dout), .core_busy(core_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   localparam logic [9:0] STOPEV = 10'h200;

   // Event log of observed pulses: {is_stop, rw, din}.
   logic [9:0] evlog[$];
   int n_starts = 0;
   int overlap = 0;
   always @(negedge clock) begin
      if (core_start) begin
         evlog.push_back({1'b0, core_rw, core_din});
         n_starts++;
      end
      if (core_stop) evlog.push_back(STOPEV);
      if (core_start && core_stop) overlap++;
   end

   // Behavioural iic_core: busy rises d cycles after a pulse and lasts len cycles.
   int   base_starts = 0;
   int   long_on = 0;
   bit   mute = 1'b0;
   int   max_dly = 1;
   int   fix_len = 0;
   bit   use_fix_rd = 1'b0;
   logic [7:0] fix_rd = 8'h00;
   int   busy_cnt = 0;
   int   dly = 0;
   int   pend_len = 0;
   logic [7:0] mdl_rdata = 8'h00;
   assign core_busy = (busy_cnt != 0);

   always @(posedge clock) begin
      int d;
      int len;
      logic [7:0] rd;
      d   = $urandom_range(1, max_dly);
      len = (fix_len != 0) ? fix_len : $urandom_range(1, 20);
      if (core_start && long_on != 0 && (n_starts - base_starts) == long_on) len = 2000;
      if ((core_start && !mute) || core_stop) begin
         if (core_start && core_rw) begin
            rd = use_fix_rd ? fix_rd : 8'($urandom);
            core_dout <= rd;
            mdl_rdata <= rd;
         end
         if (d == 1) begin
            busy_cnt <= len;
         end else begin
            dly      <= d - 1;
            pend_len <= len;
         end
      end else if (dly != 0) begin
         dly <= dly - 1;
         if (dly == 1) busy_cnt <= pend_len;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   // Reference: pulse list straight from the request, truncated by an abort.
   logic [9:0] expq[$];
   int ev_base = 0;
   logic [7:0] exp_rdata = 8'h00;

   task automatic build_exp(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input int abort_after);
      logic [9:0] full[$];
      int ns;
      expq.delete();
      if (rw) full = '{{2'b00, dev, 1'b0}, {2'b00, rg}, STOPEV, {2'b00, dev, 1'b1},
                       {2'b01, 8'h00}, STOPEV};
      else    full = '{{2'b00, dev, 1'b0}, {2'b00, rg}, {2'b00, wd}, STOPEV};
      if (abort_after == 0) begin
         expq = full;
      end else begin
         ns = 0;
         foreach (full[i]) begin
            if (ns < abort_after && full[i] != STOPEV) begin
               expq.push_back(full[i]);
               ns++;
            end
         end
         expq.push_back(STOPEV);
      end
   endtask

   task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, output int waited);
      waited = 0;
      req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
      while (!req_ready && waited < 6000) begin
         @(negedge clock);
         waited++;
      end
      chk("accept", req_ready, 1);
      @(posedge clock);
      base_starts = n_starts;
      ev_base = evlog.size();
      @(negedge clock);
   endtask

   task automatic finish_txn(input string tag, input logic rw, input logic exp_err);
      int cyc = 0;
      bit ready_seen = 1'b0;
      while (!rsp_valid && cyc < 6000) begin
         if (req_ready) ready_seen = 1'b1;
         @(negedge clock);
         cyc++;
      end
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_ready_low"}, ready_seen, 0);
      chk({tag, "_err"}, rsp_err, exp_err);
      if (rw && !exp_err) exp_rdata = mdl_rdata;
      chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_nev"}, evlog.size() - ev_base, expq.size());
      foreach (expq[i]) begin
         if (ev_base + i < evlog.size())
            chk($sformatf("%s_ev%0d", tag, i), evlog[ev_base + i], expq[i]);
      end
      @(negedge clock);
      chk({tag, "_pulse_end"}, rsp_valid, 0);
      chk({tag, "_ready_back"}, req_ready, 1);
   endtask

   task automatic run_txn(input string tag, input logic rw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd, input int abort_after);
      int w;
      issue(rw, dev, rg, wd, w);
      req_valid = 1'b0;
      req_rw = 1'($urandom); req_dev = 7'($urandom);
      req_reg = 8'($urandom); req_wdata = 8'($urandom);
      build_exp(rw, dev, rg, wd, abort_after);
      finish_txn(tag, rw, abort_after != 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      int w;
      int cyc;
      bit rsp_flag;
      logic r_rw;
      logic [6:0] r_dev;
      logic [7:0] r_reg;
      logic [7:0] r_wd;

      #1;
      chk("rst_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, core_start, core_stop,
                          core_rw, core_din}, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_ready", req_ready, 1);

      max_dly = 1; fix_len = 18;
      run_txn("wr", 1'b0, 7'h50, 8'h10, 8'hAA, 0);

      use_fix_rd = 1'b1; fix_rd = 8'h3C;
      run_txn("rd", 1'b1, 7'h50, 8'h55, 8'h00, 0);
      chk("rd_3c", rsp_rdata, 8'h3C);
      use_fix_rd = 1'b0;

      fix_len = 0; max_dly = 4;
      mute = 1'b1;
      run_txn("noacc", 1'b0, 7'h2B, 8'h01, 8'h5A, 1);
      mute = 1'b0;
      run_txn("after_noacc", 1'b1, 7'h11, 8'h22, 8'h00, 0);

      long_on = 2;
      run_txn("longbusy", 1'b0, 7'h33, 8'h44, 8'h66, 2);
      long_on = 0;

      // Reset during the second byte's busy window.
      fix_len = 40; max_dly = 1;
      issue(1'b0, 7'h50, 8'h20, 8'h77, w);
      req_valid = 1'b0;
      cyc = 0;
      while (!((n_starts - base_starts) >= 2 && core_busy) && cyc < 400) begin
         @(negedge clock);
         cyc++;
      end
      chk("mid_second_busy", core_busy, 1);
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, core_start, core_stop,
                              core_rw, core_din}, 0);
      exp_rdata = 8'h00;
      rsp_flag = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (rsp_valid) rsp_flag = 1'b1;
      end
      reset_n = 1'b1;
      @(negedge clock);
      chk("mid_rst_ready", req_ready, 1);
      cyc = 0;
      while (core_busy && cyc < 400) begin
         if (rsp_valid) rsp_flag = 1'b1;
         @(negedge clock);
         cyc++;
      end
      chk("mid_rst_no_rsp", rsp_flag, 0);
      fix_len = 0; max_dly = 4;

      // Two back-to-back requests with req_valid held high.
      issue(1'b0, 7'h0A, 8'h0B, 8'h0C, w);
      req_rw = 1'b1; req_dev = 7'h3D; req_reg = 8'hE0; req_wdata = 8'h99;
      build_exp(1'b0, 7'h0A, 8'h0B, 8'h0C, 0);
      finish_txn("qa", 1'b0, 1'b0);
      issue(1'b1, 7'h3D, 8'hE0, 8'h99, w);
      chk("qb_accept_wait", w, 0);
      req_valid = 1'b0;
      build_exp(1'b1, 7'h3D, 8'hE0, 8'h99, 0);
      finish_txn("qb", 1'b1, 1'b0);

      for (int i = 0; i < 20; i++) begin
         r_rw = 1'($urandom); r_dev = 7'($urandom);
         r_reg = 8'($urandom); r_wd = 8'($urandom);
         run_txn($sformatf("rnd%0d", i), r_rw, r_dev, r_reg, r_wd, 0);
      end

      chk("start_stop_overlap", overlap, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
